// File: rtl/inst_fetch_buf_pkg.sv
// Shared widths, exception codes and types for the instruction fetch buffer.
package inst_fetch_buf_pkg;

  localparam int INST_W  = 32;
  localparam int ECODE_W = 6;

  // Fetch-side exception codes that can arrive with pf_ex.
  localparam logic [ECODE_W-1:0] ECODE_PIF  = 6'h03;
  localparam logic [ECODE_W-1:0] ECODE_PPI  = 6'h07;
  localparam logic [ECODE_W-1:0] ECODE_ADEF = 6'h08;
  localparam logic [ECODE_W-1:0] ECODE_TLBR = 6'h3f;

  typedef enum logic {
    REQ_IDLE = 1'b0,
    REQ_HOLD = 1'b1
  } req_state_t;

  // One buffered fetch result; exception entries carry inst = 0.
  typedef struct packed {
    logic [INST_W-1:0]  inst;
    logic               ex;
    logic [ECODE_W-1:0] ecode;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_buf_if.sv
// Pre-IF, inst SRAM bus and IF->ID signals of the fetch buffer.
interface inst_fetch_buf_if;
  import inst_fetch_buf_pkg::*;

  logic               pf_valid;
  logic [INST_W-1:0]  pf_pa;
  logic               pf_ex;
  logic [ECODE_W-1:0] pf_ecode;
  logic               pf_ready;

  logic               inst_sram_req;
  logic [INST_W-1:0]  inst_sram_addr;
  logic               inst_sram_addr_ok;
  logic               inst_sram_data_ok;
  logic [INST_W-1:0]  inst_sram_rdata;

  logic               fs_valid;
  logic [INST_W-1:0]  fs_inst;
  logic               fs_ex;
  logic [ECODE_W-1:0] fs_ecode;
  logic               ds_allowin;

  // Environment side: pre-IF, bus slave and decode stage.
  modport master (
    output pf_valid, pf_pa, pf_ex, pf_ecode,
    input  pf_ready,
    input  inst_sram_req, inst_sram_addr,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  fs_valid, fs_inst, fs_ex, fs_ecode,
    output ds_allowin
  );

  // Fetch buffer side.
  modport slave (
    input  pf_valid, pf_pa, pf_ex, pf_ecode,
    output pf_ready,
    output inst_sram_req, inst_sram_addr,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output fs_valid, fs_inst, fs_ex, fs_ecode,
    input  ds_allowin
  );

endinterface

// File: rtl/inst_fetch_buf_fetch_fifo.sv
// In-order buffer of fetch results with push/pop/clear and occupancy count.
module fetch_fifo
  import inst_fetch_buf_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         clear,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);

  // Sized to the pointer range so every pointer value indexes a real entry.
  fetch_entry_t    mem_reg [2**CW];
  logic [CW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   wr_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            do_push;
  logic            do_pop;

  function automatic logic [CW-1:0] ptr_inc(input logic [CW-1:0] p);
    return (p == LAST_C) ? '0 : p + CW'(1);
  endfunction

  assign do_pop  = pop && (count_reg != '0) && !clear;
  assign do_push = push && !clear && ((count_reg != DEPTH_C) || do_pop);

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers and count; clear empties the buffer in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch_buf.sv
// Instruction fetch buffer: issues inst-bus requests for translated PCs,
// drops responses made stale by a flush, and queues results for decode.
module inst_fetch_buf
  import inst_fetch_buf_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input logic              clk,
  input logic              reset,
  input logic              flush,
  inst_fetch_buf_if.slave  bus
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  req_state_t        state_reg;
  logic [INST_W-1:0] hold_addr_reg;
  logic              hold_kill_reg;
  logic [CW-1:0]     outstanding_reg;
  logic [CW-1:0]     outstanding_next;
  logic [CW-1:0]     discard_reg;
  logic [CW-1:0]     discard_next;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       occ;

  logic              idle_issue;
  logic              idle_ex;
  logic              accept;
  logic              hold_done;
  logic              resp_valid;
  logic              resp_drop;
  logic              fifo_push;
  fetch_entry_t      fifo_push_data;
  fetch_entry_t      fifo_head;

  // Every slot in flight (requested or buffered) reserves a FIFO entry.
  assign occ = {1'b0, outstanding_reg} + {1'b0, fifo_count};

  assign idle_issue = (state_reg == REQ_IDLE) && bus.pf_valid && !bus.pf_ex &&
                      !flush && (occ < {1'b0, DEPTH_C});
  // Exception PCs wait for all older requests so they stay in program order.
  assign idle_ex    = (state_reg == REQ_IDLE) && bus.pf_valid && bus.pf_ex &&
                      !flush && (outstanding_reg == '0) && (fifo_count < DEPTH_C);

  assign bus.inst_sram_req  = !reset && ((state_reg == REQ_HOLD) || idle_issue);
  assign bus.inst_sram_addr = reset                   ? '0 :
                              (state_reg == REQ_HOLD) ? hold_addr_reg :
                              idle_issue              ? bus.pf_pa : '0;

  assign accept     = bus.inst_sram_req && bus.inst_sram_addr_ok;
  assign hold_done  = (state_reg == REQ_HOLD) && bus.inst_sram_addr_ok;
  assign resp_valid = bus.inst_sram_data_ok && (outstanding_reg != '0);
  assign resp_drop  = resp_valid && (discard_reg != '0);

  // A request killed by a flush while held must not advance pre-IF.
  assign bus.pf_ready = !reset && !flush &&
                        ((idle_issue && bus.inst_sram_addr_ok) ||
                         (hold_done && !hold_kill_reg) || idle_ex);

  assign fifo_push      = !flush && ((resp_valid && !resp_drop) || idle_ex);
  assign fifo_push_data = idle_ex ? '{inst: '0, ex: 1'b1, ecode: bus.pf_ecode}
                                  : '{inst: bus.inst_sram_rdata, ex: 1'b0, ecode: '0};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (bus.fs_valid && bus.ds_allowin),
    .clear     (flush),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign bus.fs_valid = (fifo_count != '0);
  assign bus.fs_inst  = bus.fs_valid ? fifo_head.inst  : '0;
  assign bus.fs_ex    = bus.fs_valid && fifo_head.ex;
  assign bus.fs_ecode = bus.fs_valid ? fifo_head.ecode : '0;

  // Next values of the in-flight and stale-response counters.
  always_comb begin
    outstanding_next = outstanding_reg + CW'(accept) - CW'(resp_valid);
    if (flush) begin
      // Everything still in flight after this edge belongs to the old path.
      discard_next = outstanding_next;
    end else begin
      discard_next = discard_reg - CW'(resp_drop) + CW'(hold_done && hold_kill_reg);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding_reg <= '0;
      discard_reg     <= '0;
    end else begin
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
    end
  end

  // Request FSM: HOLD keeps req/addr stable until the bus accepts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= REQ_IDLE;
      hold_addr_reg <= '0;
      hold_kill_reg <= 1'b0;
    end else begin
      case (state_reg)
        REQ_IDLE: begin
          if (idle_issue && !bus.inst_sram_addr_ok) begin
            state_reg     <= REQ_HOLD;
            hold_addr_reg <= bus.pf_pa;
            hold_kill_reg <= 1'b0;
          end
        end
        REQ_HOLD: begin
          if (bus.inst_sram_addr_ok) begin
            state_reg     <= REQ_IDLE;
            hold_kill_reg <= 1'b0;
          end else if (flush) begin
            hold_kill_reg <= 1'b1;
          end
        end
        default: state_reg <= REQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Directed bench for inst_fetch_buf with a simple inst-bus responder.
module tb_inst_fetch_buf;
  import inst_fetch_buf_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  always #5 clk = ~clk;

  inst_fetch_buf_if bus();

  inst_fetch_buf #(.DEPTH(2), .CW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Bus responder controls
  logic [31:0] resp_q[$];
  int          req_age   = 0;
  int          ack_delay = 0;
  bit          ack_en    = 1'b0;
  bit          resp_en   = 1'b0;
  bit          acc_seen  = 1'b0;
  bit          req_seen  = 1'b0;
  logic [31:0] acc_addr  = '0;

  // ID-side collector
  logic [38:0] got_q[$];
  int          acc_cnt   = 0;
  int          pop_cnt   = 0;
  int          max_occ   = 0;
  bit          track_occ = 1'b0;

  assign bus.inst_sram_addr_ok = bus.inst_sram_req && ack_en && (req_age >= ack_delay);

  function automatic logic [31:0] resp_data(input logic [31:0] a);
    case (a)
      32'h1C001000: return 32'hAAAA0000;
      32'h1C001004: return 32'hBBBB0000;
      32'h1C008000: return 32'h12345678;
      default:      return ~a;
    endcase
  endfunction

  // Responder: data_ok exactly one cycle after acceptance, in order.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (acc_seen) begin
        resp_q.push_back(acc_addr);
        req_age = 0;
      end else if (req_seen) begin
        req_age++;
      end else begin
        req_age = 0;
      end
      if (resp_en && resp_q.size() > 0) begin
        bus.inst_sram_data_ok = 1'b1;
        bus.inst_sram_rdata   = resp_data(resp_q.pop_front());
      end else begin
        bus.inst_sram_data_ok = 1'b0;
        bus.inst_sram_rdata   = '0;
      end
    end
  end

  // Mid-cycle monitor of bus acceptance and ID pops.
  initial begin
    forever begin
      @(negedge clk);
      if (track_occ && (acc_cnt - pop_cnt) > max_occ) max_occ = acc_cnt - pop_cnt;
      acc_seen = bus.inst_sram_req && bus.inst_sram_addr_ok;
      req_seen = bus.inst_sram_req;
      acc_addr = bus.inst_sram_addr;
      if (acc_seen) acc_cnt++;
      if (bus.fs_valid && bus.ds_allowin) begin
        got_q.push_back({bus.fs_ex, bus.fs_ecode, bus.fs_inst});
        pop_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one PC and wait (bounded) for pf_ready.
  task automatic issue_pc(input logic [31:0] pa, input logic ex, input logic [5:0] ec);
    bit done = 1'b0;
    bus.pf_valid = 1'b1;
    bus.pf_pa    = pa;
    bus.pf_ex    = ex;
    bus.pf_ecode = ec;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (bus.pf_ready) done = 1'b1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL issue_pc pa=%h pf_ready=0 required=1", pa);
    end
    tick();
    bus.pf_valid = 1'b0;
    bus.pf_ex    = 1'b0;
    bus.pf_ecode = '0;
  endtask

  task automatic wait_got(input int n, input string tag);
    for (int c = 0; c < 60 && got_q.size() < n; c++) tick();
    total++;
    if (got_q.size() < n) begin
      bad++;
      $display("FAIL %s_timeout got_count=%0d required=%0d", tag, got_q.size(), n);
    end
  endtask

  task automatic check_got(input int idx, input logic [38:0] exp, input string tag);
    logic [38:0] act;
    act = (got_q.size() > idx) ? got_q[idx] : 39'h7f_ffff_ffff;
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h required=%h", tag, act, exp);
    end
    $display("txn %s entry=%h", tag, act);
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0;
    bus.pf_valid = 1'b1; bus.pf_pa = 32'h1C000000; bus.pf_ex = 1'b0; bus.pf_ecode = '0;
    bus.ds_allowin = 1'b1; bus.inst_sram_data_ok = 1'b0; bus.inst_sram_rdata = '0;
    ack_en = 1'b1; ack_delay = 0; resp_en = 1'b1;
    #2;
    total += 5;
    if (bus.inst_sram_req !== 1'b0)  begin bad++; $display("FAIL reset_req got=%b required=0", bus.inst_sram_req); end
    if (bus.inst_sram_addr !== '0)   begin bad++; $display("FAIL reset_addr got=%h required=0", bus.inst_sram_addr); end
    if (bus.pf_ready !== 1'b0)       begin bad++; $display("FAIL reset_pf_ready got=%b required=0", bus.pf_ready); end
    if (bus.fs_valid !== 1'b0)       begin bad++; $display("FAIL reset_fs_valid got=%b required=0", bus.fs_valid); end
    if (bus.fs_inst !== '0)          begin bad++; $display("FAIL reset_fs_inst got=%h required=0", bus.fs_inst); end
    tick(); tick();
    bus.pf_valid = 1'b0;
    reset = 1'b0;
    tick();
    $display("txn reset done");
  endtask

  task automatic test_stream();
    logic [31:0] base = 32'h1C000000;
    got_q.delete(); acc_cnt = 0; pop_cnt = 0; max_occ = 0; track_occ = 1'b1;
    for (int i = 0; i < 3; i++) issue_pc(base + 32'(4 * i), 1'b0, '0);
    wait_got(3, "stream");
    tick(); tick();
    track_occ = 1'b0;
    check_got(0, {7'd0, 32'hE3FFFFFF}, "stream_inst0");
    check_got(1, {7'd0, 32'hE3FFFFFB}, "stream_inst1");
    check_got(2, {7'd0, 32'hE3FFFFF7}, "stream_inst2");
    total++;
    if (max_occ > 2 || max_occ < 1) begin
      bad++; $display("FAIL stream_occ got=%0d required=1..2", max_occ);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] base = 32'h1C000100;
    int cnt = 0;
    got_q.delete();
    bus.ds_allowin = 1'b0;
    bus.pf_valid = 1'b1; bus.pf_pa = base;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.pf_ready) cnt++;
      tick();
      bus.pf_pa = base + 32'(4 * cnt);
    end
    #1;
    total += 2;
    if (cnt != 2) begin bad++; $display("FAIL bp_accepts got=%0d required=2", cnt); end
    if (bus.inst_sram_req !== 1'b0) begin bad++; $display("FAIL bp_req_stall got=%b required=0", bus.inst_sram_req); end
    bus.ds_allowin = 1'b1;
    #1;
    total++;
    if (bus.inst_sram_req !== 1'b0) begin bad++; $display("FAIL bp_req_pop_cycle got=%b required=0", bus.inst_sram_req); end
    tick();
    #1;
    total += 2;
    if (bus.inst_sram_req !== 1'b1) begin bad++; $display("FAIL bp_req_resume got=%b required=1", bus.inst_sram_req); end
    if (bus.inst_sram_addr !== base + 32'd8) begin
      bad++; $display("FAIL bp_addr_resume got=%h required=%h", bus.inst_sram_addr, base + 32'd8);
    end
    @(negedge clk);
    total++;
    if (bus.pf_ready !== 1'b1) begin bad++; $display("FAIL bp_pf_ready got=%b required=1", bus.pf_ready); end
    tick();
    bus.pf_valid = 1'b0;
    wait_got(3, "bp");
    check_got(0, {7'd0, ~base}, "bp_inst0");
    check_got(1, {7'd0, ~(base + 32'd4)}, "bp_inst1");
    check_got(2, {7'd0, ~(base + 32'd8)}, "bp_inst2");
  endtask

  task automatic test_flush_outstanding();
    got_q.delete();
    resp_en = 1'b0;
    issue_pc(32'h1C001000, 1'b0, '0);
    issue_pc(32'h1C001004, 1'b0, '0);
    flush = 1'b1;
    bus.pf_valid = 1'b1; bus.pf_pa = 32'h1C008000;
    #1;
    total += 2;
    if (bus.pf_ready !== 1'b0) begin bad++; $display("FAIL flush_pf_ready got=%b required=0", bus.pf_ready); end
    if (bus.inst_sram_req !== 1'b0) begin bad++; $display("FAIL flush_req got=%b required=0", bus.inst_sram_req); end
    tick();
    flush = 1'b0;
    resp_en = 1'b1;
    issue_pc(32'h1C008000, 1'b0, '0);
    wait_got(1, "flush");
    for (int c = 0; c < 4; c++) tick();
    total++;
    if (got_q.size() != 1) begin bad++; $display("FAIL flush_count got=%0d required=1", got_q.size()); end
    check_got(0, {7'd0, 32'h12345678}, "flush_inst");
  endtask

  task automatic test_flush_hold();
    logic [31:0] h0 = 32'h1C002000;
    logic [31:0] h1 = 32'h1C003000;
    got_q.delete();
    ack_delay = 3;
    bus.pf_valid = 1'b1; bus.pf_pa = h0;
    #1;
    total++;
    if (bus.inst_sram_req !== 1'b1 || bus.inst_sram_addr !== h0) begin
      bad++; $display("FAIL hold_issue req=%b addr=%h required req=1 addr=%h", bus.inst_sram_req, bus.inst_sram_addr, h0);
    end
    tick();
    flush = 1'b1; bus.pf_pa = h1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total += 2;
      if (bus.inst_sram_addr !== h0) begin bad++; $display("FAIL hold_addr_c%0d got=%h required=%h", c, bus.inst_sram_addr, h0); end
      if (bus.pf_ready !== 1'b0) begin bad++; $display("FAIL hold_pf_ready_c%0d got=%b required=0", c, bus.pf_ready); end
      tick();
      flush = 1'b0;
    end
    ack_delay = 0;
    issue_pc(h1, 1'b0, '0);
    wait_got(1, "hold");
    for (int c = 0; c < 4; c++) tick();
    total++;
    if (got_q.size() != 1) begin bad++; $display("FAIL hold_count got=%0d required=1", got_q.size()); end
    check_got(0, {7'd0, 32'hE3FFCFFF}, "hold_inst");
  endtask

  task automatic test_exception();
    got_q.delete();
    resp_en = 1'b0;
    issue_pc(32'h1C004000, 1'b0, '0);
    bus.pf_valid = 1'b1; bus.pf_pa = 32'h1C004004; bus.pf_ex = 1'b1; bus.pf_ecode = ECODE_TLBR;
    for (int c = 0; c < 3; c++) begin
      #1;
      total += 2;
      if (bus.pf_ready !== 1'b0) begin bad++; $display("FAIL ex_wait_pf_ready got=%b required=0", bus.pf_ready); end
      if (bus.inst_sram_req !== 1'b0) begin bad++; $display("FAIL ex_wait_req got=%b required=0", bus.inst_sram_req); end
      tick();
    end
    resp_en = 1'b1;
    issue_pc(32'h1C004004, 1'b1, ECODE_TLBR);
    wait_got(2, "ex");
    check_got(0, {7'd0, 32'hE3FFBFFF}, "ex_inst_first");
    check_got(1, {1'b1, ECODE_TLBR, 32'd0}, "ex_entry");
  endtask

  task automatic test_async_reset_hold();
    got_q.delete();
    bus.ds_allowin = 1'b0;
    issue_pc(32'h1C005000, 1'b0, '0);
    tick();
    ack_delay = 5;
    bus.pf_valid = 1'b1; bus.pf_pa = 32'h1C005004;
    tick();
    total += 2;
    if (bus.inst_sram_req !== 1'b1) begin bad++; $display("FAIL areset_pre_req got=%b required=1", bus.inst_sram_req); end
    if (bus.fs_valid !== 1'b1) begin bad++; $display("FAIL areset_pre_fs_valid got=%b required=1", bus.fs_valid); end
    #1;
    reset = 1'b1;
    #1;
    total += 3;
    if (bus.inst_sram_req !== 1'b0) begin bad++; $display("FAIL areset_req got=%b required=0", bus.inst_sram_req); end
    if (bus.fs_valid !== 1'b0) begin bad++; $display("FAIL areset_fs_valid got=%b required=0", bus.fs_valid); end
    if (bus.pf_ready !== 1'b0) begin bad++; $display("FAIL areset_pf_ready got=%b required=0", bus.pf_ready); end
    $display("txn async reset mid-hold req=%b fs_valid=%b", bus.inst_sram_req, bus.fs_valid);
    tick();
    bus.pf_valid = 1'b0;
    reset = 1'b0;
    ack_delay = 0;
    resp_q.delete();
    bus.ds_allowin = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_outstanding();
    test_flush_hold();
    test_exception();
    test_async_reset_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
